// File: rtl/acc_cpu_hs.sv
// Single-accumulator CPU with a req/ack memory port, one-level indirect addressing
// through a pointer word, sticky self-jump halt detection and a retire strobe.
module acc_cpu_hs #(
   parameter int DW       = 16,
   parameter int AW       = 13,
   parameter int PTR_ADDR = 2
) (
   input  logic          clk,
   input  logic          rst,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic [AW-1:0] PC,
   output logic [DW-1:0] W,
   output logic          halted,
   output logic          instr_done
);

   localparam int SW = $clog2(DW);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_NOR  = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_GT   = 3'b011;
   localparam logic [2:0] OP_SZ   = 3'b100;
   localparam logic [2:0] OP_CP2W = 3'b101;
   localparam logic [2:0] OP_CPFW = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   typedef enum logic [1:0] {S_FETCH, S_INDIR, S_EXEC, S_HALT} state_t;

   state_t        state_reg;
   logic [AW-1:0] pc_reg;
   logic [AW-1:0] ea_reg;
   logic [DW-1:0] w_reg;
   logic [DW-1:0] ir_reg;
   logic          halted_reg;

   logic [2:0]    op;
   logic [AW-1:0] pc_inc;
   logic [DW-1:0] w_next;
   logic [AW-1:0] pc_next;
   logic          halt_hit;
   logic [DW-1:0] sh_res;
   logic [SW-1:0] sh_k;
   logic [1:0]    sh_sel;
   logic [2*DW-1:0] w_dbl;
   logic          unused_ir;

   assign op        = ir_reg[DW-1:DW-3];
   assign unused_ir = ^ir_reg[DW-4:0];
   assign pc_inc    = pc_reg + AW'(1);

   assign PC        = pc_reg;
   assign W         = w_reg;
   assign halted    = halted_reg;
   assign mem_wdata = w_reg;

   // Memory port is a pure decode of the state; reset forces it idle in the same cycle.
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = pc_reg;
      case (state_reg)
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc_reg;
         end
         S_INDIR: begin
            mem_req  = 1'b1;
            mem_addr = AW'(PTR_ADDR);
         end
         S_EXEC: begin
            mem_req  = 1'b1;
            mem_addr = ea_reg;
            mem_we   = (op == OP_CPFW);
         end
         default: begin
            mem_req  = 1'b0;
         end
      endcase
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
      end
   end

   assign instr_done = (state_reg == S_EXEC) && mem_ack && !rst;

   // Every shift/rotate amount is built in parallel; the operand's low bits pick one.
   logic [DW-1:0] shr_arr  [DW];
   logic [DW-1:0] shl_arr  [DW];
   logic [DW-1:0] rotr_arr [DW];
   logic [DW-1:0] rotl_arr [DW];

   assign w_dbl = {w_reg, w_reg};

   genvar gi;
   generate
      for (gi = 0; gi < DW; gi++) begin : g_shift
         assign shr_arr[gi]  = w_reg >> gi;
         assign shl_arr[gi]  = w_reg << gi;
         assign rotr_arr[gi] = w_dbl[gi +: DW];
         assign rotl_arr[gi] = w_dbl[DW-gi +: DW];
      end
   endgenerate

   assign sh_k   = mem_rdata[SW-1:0];
   assign sh_sel = mem_rdata[SW+1:SW];

   always_comb begin
      case (sh_sel)
         2'd0:    sh_res = shr_arr[sh_k];
         2'd1:    sh_res = shl_arr[sh_k];
         2'd2:    sh_res = rotr_arr[sh_k];
         default: sh_res = rotl_arr[sh_k];
      endcase
   end

   always_comb begin
      w_next   = w_reg;
      pc_next  = pc_inc;
      halt_hit = 1'b0;
      case (op)
         OP_ADD:  w_next = w_reg + mem_rdata;
         OP_NOR:  w_next = ~(w_reg | mem_rdata);
         OP_SHR:  w_next = sh_res;
         OP_GT:   w_next = (w_reg > mem_rdata) ? DW'(1) : '0;
         OP_SZ: begin
            if (mem_rdata == '0)
               pc_next = pc_reg + AW'(2);
         end
         OP_CP2W: w_next = mem_rdata;
         OP_CPFW: w_next = w_reg;
         default: begin
            pc_next  = mem_rdata[AW-1:0];
            halt_hit = (mem_rdata[AW-1:0] == pc_reg);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_FETCH;
         pc_reg     <= '0;
         w_reg      <= '0;
         ir_reg     <= '0;
         ea_reg     <= '0;
         halted_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               if (mem_ack) begin
                  ir_reg    <= mem_rdata;
                  ea_reg    <= mem_rdata[AW-1:0];
                  state_reg <= (mem_rdata[AW-1:0] == '0) ? S_INDIR : S_EXEC;
               end
            end
            S_INDIR: begin
               // Single level: the pointer word is used as-is, even when it is zero.
               if (mem_ack) begin
                  ea_reg    <= mem_rdata[AW-1:0];
                  state_reg <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (mem_ack) begin
                  w_reg  <= w_next;
                  pc_reg <= pc_next;
                  if (halt_hit) begin
                     halted_reg <= 1'b1;
                     state_reg  <= S_HALT;
                  end else begin
                     state_reg  <= S_FETCH;
                  end
               end
            end
            default: begin
               state_reg <= S_HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_cpu_hs.sv
// Directed bench for acc_cpu_hs: behavioural memory with programmable ack delay,
// one task per scenario, hand-computed expectations.
module tb_acc_cpu_hs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req, mem_we, mem_ack;
   logic [12:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [12:0] pc;
   logic [15:0] w;
   logic        halted, instr_done;

   logic [15:0] mem [0:8191];
   int          ack_delay = 0;
   int          wait_cnt  = 0;
   logic        load_en   = 1'b0;
   logic [12:0] load_addr = '0;
   logic [15:0] load_data = '0;

   int checks = 0;
   int errors = 0;

   acc_cpu_hs dut (
      .clk        (clk),
      .rst        (rst),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .PC         (pc),
      .W          (w),
      .halted     (halted),
      .instr_done (instr_done)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

   always @(posedge clk) begin
      if (load_en)
         mem[load_addr] <= load_data;
      else if (mem_req && mem_ack && mem_we)
         mem[mem_addr] <= mem_wdata;
      if (rst || !mem_req || mem_ack)
         wait_cnt <= 0;
      else
         wait_cnt <= wait_cnt + 1;
   end

   task automatic load(input logic [12:0] a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(posedge clk);
      #1 load_en = 1'b0;
   endtask

   // Releases reset just after a rising edge; the next negedge lies in cycle 1.
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_retire();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (instr_done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL retire_timeout: instr_done got 0 want 1 within 60 cycles (PC=%0d)", pc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load_t1_prog();
      rst = 1'b1;
      load(13'd0,  16'hA014);
      load(13'd20, 16'd7);
      load(13'd1,  16'h0015);
      load(13'd21, 16'd9);
      load(13'd2,  16'hC016);
      load(13'd22, 16'd0);
      load(13'd3,  16'hE004);
      load(13'd4,  16'd3);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
      checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", instr_done); end
      checks++; if (pc !== 13'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
      checks++; if (w !== 16'd0) begin errors++; $display("FAIL reset_w: got %h want 0000", w); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
      $display("test_reset: done");
   endtask

   task automatic test_direct();
      load_t1_prog();
      ack_delay = 0;
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c <= 8) begin
            checks++;
            if (instr_done !== (c % 2 == 0)) begin
               errors++; $display("FAIL t1_done cycle %0d: got %b want %b", c, instr_done, (c % 2 == 0));
            end
         end
         if (c == 3) begin
            checks++; if (w !== 16'd7) begin errors++; $display("FAIL t1_w_cp2w: got %h want 0007", w); end
         end
         if (c == 5) begin
            checks++; if (w !== 16'd16) begin errors++; $display("FAIL t1_w_add: got %h want 0010", w); end
         end
         if (c == 7) begin
            checks++; if (mem[22] !== 16'd16) begin errors++; $display("FAIL t1_store: got %h want 0010", mem[22]); end
         end
         if (c == 9) begin
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL t1_halted: got %b want 1", halted); end
            checks++; if (pc !== 13'd3) begin errors++; $display("FAIL t1_pc: got %0d want 3", pc); end
         end
         if (c == 10) begin
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL t1_halt_req: got %b want 0", mem_req); end
         end
      end
      $display("test_direct: W=%h mem[22]=%h", w, mem[22]);
   endtask

   task automatic test_slow_ack();
      logic        prev_pend;
      logic [12:0] prev_addr;
      logic        prev_we;
      load_t1_prog();
      ack_delay = 3;
      do_reset();
      prev_pend = 1'b0;
      prev_addr = '0;
      prev_we   = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         @(negedge clk);
         if (prev_pend) begin
            checks++;
            if (mem_addr !== prev_addr) begin
               errors++; $display("FAIL t2_addr_stable cycle %0d: got %0d want %0d", c, mem_addr, prev_addr);
            end
            checks++;
            if (mem_we !== prev_we) begin
               errors++; $display("FAIL t2_we_stable cycle %0d: got %b want %b", c, mem_we, prev_we);
            end
         end
         prev_pend = mem_req && !mem_ack;
         prev_addr = mem_addr;
         prev_we   = mem_we;
         if (c <= 32) begin
            checks++;
            if (instr_done !== (c % 8 == 0)) begin
               errors++; $display("FAIL t2_done cycle %0d: got %b want %b", c, instr_done, (c % 8 == 0));
            end
         end
         if (c == 9) begin
            checks++; if (w !== 16'd7) begin errors++; $display("FAIL t2_w_cp2w: got %h want 0007", w); end
         end
         if (c == 17) begin
            checks++; if (w !== 16'd16) begin errors++; $display("FAIL t2_w_add: got %h want 0010", w); end
         end
         if (c == 25) begin
            checks++; if (mem[22] !== 16'd16) begin errors++; $display("FAIL t2_store: got %h want 0010", mem[22]); end
         end
         if (c == 33) begin
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL t2_halted: got %b want 1", halted); end
         end
      end
      ack_delay = 0;
      $display("test_slow_ack: W=%h mem[22]=%h", w, mem[22]);
   endtask

   task automatic test_indirect();
      rst = 1'b1;
      load(13'd0,  16'hA000);
      load(13'd2,  16'd30);
      load(13'd30, 16'd5);
      load(13'd1,  16'hE003);
      load(13'd3,  16'd1);
      ack_delay = 0;
      do_reset();
      @(negedge clk);
      checks++; if (mem_addr !== 13'd0) begin errors++; $display("FAIL t3_fetch_addr: got %0d want 0", mem_addr); end
      @(negedge clk);
      checks++; if (mem_addr !== 13'd2) begin errors++; $display("FAIL t3_ptr_addr: got %0d want 2", mem_addr); end
      checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL t3_early_done: got %b want 0", instr_done); end
      @(negedge clk);
      checks++; if (mem_addr !== 13'd30) begin errors++; $display("FAIL t3_exec_addr: got %0d want 30", mem_addr); end
      checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL t3_done: got %b want 1", instr_done); end
      @(negedge clk);
      checks++; if (w !== 16'd5) begin errors++; $display("FAIL t3_w: got %h want 0005", w); end
      checks++; if (pc !== 13'd1) begin errors++; $display("FAIL t3_pc: got %0d want 1", pc); end
      $display("test_indirect: W=%h PC=%0d", w, pc);
   endtask

   task automatic test_shift();
      logic [15:0] ops [4];
      logic [15:0] exp [4];
      ops = '{16'd1, 16'd17, 16'd33, 16'd49};
      exp = '{16'h4000, 16'h0002, 16'hC000, 16'h0003};
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         load(13'(2 * i), 16'hA028);
         load(13'(2 * i + 1), 16'(16'h4029 + i));
         load(13'(41 + i), ops[i]);
      end
      load(13'd40, 16'h8001);
      load(13'd8,  16'hE02D);
      load(13'd45, 16'd8);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         wait_retire();
         checks++; if (w !== 16'h8001) begin errors++; $display("FAIL t4_reload %0d: got %h want 8001", i, w); end
         wait_retire();
         checks++;
         if (w !== exp[i]) begin
            errors++; $display("FAIL t4_shift op=%0d: got %h want %h", ops[i], w, exp[i]);
         end
         $display("test_shift: op=%0d W=%h", ops[i], w);
      end
      wait_retire();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL t4_halted: got %b want 1", halted); end
   endtask

   task automatic test_alu();
      rst = 1'b1;
      load(13'd0,  16'hA046);
      load(13'd1,  16'hE049);
      load(13'd2,  16'd60);
      load(13'd10, 16'h0047);
      load(13'd11, 16'h2048);
      load(13'd12, 16'hC000);
      load(13'd13, 16'h604A);
      load(13'd14, 16'h604B);
      load(13'd15, 16'hE04C);
      load(13'd60, 16'h0000);
      load(13'd70, 16'hFFFF);
      load(13'd71, 16'd2);
      load(13'd72, 16'h00F0);
      load(13'd73, 16'd10);
      load(13'd74, 16'h1000);
      load(13'd75, 16'd5);
      load(13'd76, 16'd15);
      do_reset();
      wait_retire();
      checks++; if (w !== 16'hFFFF) begin errors++; $display("FAIL alu_cp2w: got %h want ffff", w); end
      wait_retire();
      checks++; if (pc !== 13'd10) begin errors++; $display("FAIL alu_jmp: got %0d want 10", pc); end
      wait_retire();
      checks++; if (w !== 16'h0001) begin errors++; $display("FAIL alu_add_wrap: got %h want 0001", w); end
      wait_retire();
      checks++; if (w !== 16'hFF0E) begin errors++; $display("FAIL alu_nor: got %h want ff0e", w); end
      wait_retire();
      checks++; if (mem[60] !== 16'hFF0E) begin errors++; $display("FAIL alu_cpfw_indir: got %h want ff0e", mem[60]); end
      checks++; if (w !== 16'hFF0E) begin errors++; $display("FAIL alu_cpfw_w: got %h want ff0e", w); end
      wait_retire();
      checks++; if (w !== 16'h0001) begin errors++; $display("FAIL alu_gt_true: got %h want 0001", w); end
      wait_retire();
      checks++; if (w !== 16'h0000) begin errors++; $display("FAIL alu_gt_false: got %h want 0000", w); end
      wait_retire();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL alu_halted: got %b want 1", halted); end
      checks++; if (pc !== 13'd15) begin errors++; $display("FAIL alu_halt_pc: got %0d want 15", pc); end
      $display("test_alu: W=%h mem[60]=%h PC=%0d", w, mem[60], pc);
   endtask

   task automatic test_skip_halt();
      rst = 1'b1;
      load(13'd0,  16'h8032);
      load(13'd1,  16'hA035);
      load(13'd2,  16'h8033);
      load(13'd3,  16'hE034);
      load(13'd50, 16'd0);
      load(13'd51, 16'd3);
      load(13'd52, 16'd3);
      load(13'd53, 16'h1234);
      do_reset();
      wait_retire();
      checks++; if (pc !== 13'd2) begin errors++; $display("FAIL t5_sz_zero: got %0d want 2", pc); end
      checks++; if (w !== 16'd0) begin errors++; $display("FAIL t5_sz_w: got %h want 0000", w); end
      wait_retire();
      checks++; if (pc !== 13'd3) begin errors++; $display("FAIL t5_sz_nonzero: got %0d want 3", pc); end
      wait_retire();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL t5_halted: got %b want 1", halted); end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b0 || instr_done !== 1'b0) begin
            errors++; $display("FAIL t5_halt_idle cycle %0d: req=%b done=%b want 0 0", c, mem_req, instr_done);
         end
      end
      checks++; if (pc !== 13'd3) begin errors++; $display("FAIL t5_pc_frozen: got %0d want 3", pc); end
      $display("test_skip_halt: PC=%0d halted=%b", pc, halted);
   endtask

   task automatic test_reset_mid_exec();
      load_t1_prog();
      ack_delay = 3;
      do_reset();
      repeat (13) @(negedge clk);
      checks++; if (w !== 16'd7) begin errors++; $display("FAIL t6_pre_w: got %h want 0007", w); end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 13'd21 || mem_ack !== 1'b0) begin
         errors++; $display("FAIL t6_pre_exec: req=%b addr=%0d ack=%b want 1 21 0", mem_req, mem_addr, mem_ack);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL t6_rst_req: got %b want 0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL t6_rst_we: got %b want 0", mem_we); end
      checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL t6_rst_done: got %b want 0", instr_done); end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (pc !== 13'd0) begin errors++; $display("FAIL t6_pc: got %0d want 0", pc); end
      checks++; if (w !== 16'd0) begin errors++; $display("FAIL t6_w: got %h want 0000", w); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL t6_halted: got %b want 0", halted); end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 13'd0 || mem_we !== 1'b0) begin
         errors++; $display("FAIL t6_refetch: req=%b addr=%0d we=%b want 1 0 0", mem_req, mem_addr, mem_we);
      end
      ack_delay = 0;
      $display("test_reset_mid_exec: PC=%0d W=%h", pc, w);
   endtask

   initial begin
      test_reset();
      test_direct();
      test_slow_ack();
      test_indirect();
      test_shift();
      test_alu();
      test_skip_halt();
      test_reset_mid_exec();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
